sweep_limit_guard: RTL and testbench

Multi-channel sweep-continue controller for the servo sweep FSMs. Each channel holds its CONT flag high while its axis sweeps. CONT drops only when one of these happens:
- the PWM limit flag has been stable high for HOLD consecutive cycles, after an initial blanking window;
- a sweep timeout expires.

It replaces the fixed 5-bit per-axis limit counters with one parametrised block serving all axes. It adds glitch qualification, latched stop, timeout detection and a done pulse.

---
 rtl/sweep_limit_guard_if.sv | 15 +
 rtl/sweep_limit_guard.sv | 155 +++++++++++++++
 tb/tb_sweep_limit_guard.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/sweep_limit_guard_if.sv
// Handshake bundle between the servo sweep FSMs and the limit guard:
// per-channel enable/limit in, continue/done/timeout flags out.
interface sweep_limit_guard_if #(
    parameter int N_CH = 2
);
    logic [N_CH-1:0] en;
    logic [N_CH-1:0] limit;
    logic            clr_tmo;
    logic [N_CH-1:0] cont;
    logic [N_CH-1:0] done;
    logic [N_CH-1:0] tmo;

    modport master (output en, limit, clr_tmo, input cont, done, tmo);
    modport slave  (input en, limit, clr_tmo, output cont, done, tmo);
endinterface

// File: rtl/sweep_limit_guard.sv
// Multi-channel sweep-continue guard: each channel keeps CONT high until a
// blanked, glitch-qualified limit is accepted or the sweep times out.
module sweep_limit_guard_ch #(
    parameter int CNT_W     = 5,
    parameter int BLANK     = 8,
    parameter int HOLD      = 4,
    parameter int TIMEOUT_W = 16,
    parameter int TIMEOUT   = 50000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic limit_i,
    input  logic clr_tmo_i,
    output logic cont_o,
    output logic done_o,
    output logic tmo_o
);
    typedef enum logic [1:0] {IDLE, BLANKING, QUAL, STOP} state_e;

    localparam logic [CNT_W-1:0]     BLANK_LAST = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [CNT_W-1:0]     HOLD_LAST  = CNT_W'(HOLD - 1);
    localparam logic [TIMEOUT_W-1:0] TMO_LAST   = TIMEOUT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     blank_q, blank_d;
    logic [CNT_W-1:0]     hold_q, hold_d;
    logic [TIMEOUT_W-1:0] tcnt_q, tcnt_d;
    logic                 cont_q, cont_d;
    logic                 done_q, done_d;
    logic                 tmo_q, tmo_d;
    logic                 tmo_hit;
    logic                 accept;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            blank_q <= '0;
            hold_q  <= '0;
            tcnt_q  <= '0;
            cont_q  <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            blank_q <= blank_d;
            hold_q  <= hold_d;
            tcnt_q  <= tcnt_d;
            cont_q  <= cont_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        blank_d = blank_q;
        hold_d  = hold_q;
        tcnt_d  = tcnt_q;
        cont_d  = cont_q;
        done_d  = 1'b0;
        tmo_d   = clr_tmo_i ? 1'b0 : tmo_q;
        tmo_hit = (TIMEOUT > 0) && (tcnt_q == TMO_LAST);
        accept  = 1'b0;

        if (!en_i) begin
            state_d = IDLE;
            blank_d = '0;
            hold_d  = '0;
            tcnt_d  = '0;
            cont_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = (BLANK > 0) ? BLANKING : QUAL;
                    blank_d = '0;
                    hold_d  = '0;
                    tcnt_d  = '0;
                    cont_d  = 1'b1;
                end
                BLANKING: begin
                    tcnt_d  = tcnt_q + 1'b1;
                    blank_d = blank_q + 1'b1;
                    if (blank_q == BLANK_LAST) begin
                        state_d = QUAL;
                        blank_d = '0;
                        hold_d  = '0;
                    end
                end
                QUAL: begin
                    tcnt_d = tcnt_q + 1'b1;
                    if (limit_i) begin
                        if (hold_q == HOLD_LAST) accept = 1'b1;
                        else                     hold_d = hold_q + 1'b1;
                    end else begin
                        hold_d = '0;
                    end
                end
                STOP:    cont_d  = 1'b0;
                default: state_d = IDLE;
            endcase

            // Acceptance beats a timeout landing on the same edge.
            if (accept) begin
                state_d = STOP;
                cont_d  = 1'b0;
                done_d  = 1'b1;
            end else if (tmo_hit && (state_q == BLANKING || state_q == QUAL)) begin
                state_d = STOP;
                tcnt_d  = tcnt_q;
                cont_d  = 1'b0;
                tmo_d   = 1'b1;
            end
        end
    end

    assign cont_o = cont_q;
    assign done_o = done_q;
    assign tmo_o  = tmo_q;
endmodule

module sweep_limit_guard #(
    parameter int N_CH      = 2,
    parameter int CNT_W     = 5,
    parameter int BLANK     = 8,
    parameter int HOLD      = 4,
    parameter int TIMEOUT_W = 16,
    parameter int TIMEOUT   = 50000
) (
    input logic           clk_i,
    input logic           rst_i,
    sweep_limit_guard_if.slave bus
);
    logic [N_CH-1:0] cont_w, done_w, tmo_w;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        sweep_limit_guard_ch #(
            .CNT_W(CNT_W), .BLANK(BLANK), .HOLD(HOLD),
            .TIMEOUT_W(TIMEOUT_W), .TIMEOUT(TIMEOUT)
        ) u_ch (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .en_i     (bus.en[g]),
            .limit_i  (bus.limit[g]),
            .clr_tmo_i(bus.clr_tmo),
            .cont_o   (cont_w[g]),
            .done_o   (done_w[g]),
            .tmo_o    (tmo_w[g])
        );
    end

    assign bus.cont = cont_w;
    assign bus.done = done_w;
    assign bus.tmo  = tmo_w;
endmodule

// File: tb/tb_sweep_limit_guard.sv
// Randomised + directed bench; a sweep-age reference model feeds a scoreboard
// queue that a separate monitor drains after every clock edge.
module tb_sweep_limit_guard;
    localparam int N  = 2;
    localparam int BL = 8;
    localparam int HD = 4;
    localparam int TO = 100;

    typedef struct packed {
        logic [N-1:0] cont;
        logic [N-1:0] done;
        logic [N-1:0] tmo;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sweep_limit_guard_if #(.N_CH(N)) bus();

    sweep_limit_guard #(
        .N_CH(N), .CNT_W(5), .BLANK(BL), .HOLD(HD), .TIMEOUT_W(16), .TIMEOUT(TO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    exp_t q[$];
    int total = 0;
    int bad   = 0;
    int ncyc  = 0;

    // Reference model state: sweep age counts edges since the start edge.
    bit m_act[N], m_stop[N], m_cont[N], m_done[N], m_tmo[N];
    int m_age[N], m_run[N];

    task automatic model_edge(input bit r, input logic [N-1:0] en,
                              input logic [N-1:0] lim, input bit clr);
        exp_t e;
        for (int c = 0; c < N; c++) begin
            bit tset;
            tset = 0;
            m_done[c] = 0;
            if (r) begin
                m_act[c] = 0; m_stop[c] = 0; m_cont[c] = 0; m_tmo[c] = 0;
                m_age[c] = 0; m_run[c] = 0;
            end else begin
                if (!en[c]) begin
                    m_act[c] = 0; m_stop[c] = 0; m_cont[c] = 0;
                end else if (!m_act[c]) begin
                    m_act[c] = 1; m_stop[c] = 0; m_cont[c] = 1;
                    m_age[c] = 0; m_run[c] = 0;
                end else if (!m_stop[c]) begin
                    m_age[c]++;
                    if (m_age[c] > BL) m_run[c] = lim[c] ? m_run[c] + 1 : 0;
                    if (m_run[c] >= HD) begin
                        m_stop[c] = 1; m_cont[c] = 0; m_done[c] = 1;
                    end else if (TO > 0 && m_age[c] >= TO) begin
                        m_stop[c] = 1; m_cont[c] = 0; tset = 1;
                    end
                end
                m_tmo[c] = tset ? 1'b1 : (clr ? 1'b0 : m_tmo[c]);
            end
            e.cont[c] = m_cont[c];
            e.done[c] = m_done[c];
            e.tmo[c]  = m_tmo[c];
        end
        q.push_back(e);
    endtask

    // Drive one clock edge worth of inputs and record what must follow it.
    task automatic cyc(input bit r, input logic [N-1:0] en,
                       input logic [N-1:0] lim, input bit clr);
        @(negedge clk);
        rst = r;
        bus.en = en;
        bus.limit = lim;
        bus.clr_tmo = clr;
        model_edge(r, en, lim, clr);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            ncyc++;
            total += 3;
            if (bus.cont !== e.cont) begin
                bad++;
                $display("FAIL cont cyc=%0d got=%b exp=%b", ncyc, bus.cont, e.cont);
            end
            if (bus.done !== e.done) begin
                bad++;
                $display("FAIL done cyc=%0d got=%b exp=%b", ncyc, bus.done, e.done);
            end
            if (bus.tmo !== e.tmo) begin
                bad++;
                $display("FAIL tmo cyc=%0d got=%b exp=%b", ncyc, bus.tmo, e.tmo);
            end
        end
    end

    initial begin
        bus.en = '0;
        bus.limit = '0;
        bus.clr_tmo = 1'b0;

        // Reset with everything asserted, then release with only ch0 enabled
        for (int i = 0; i < 3; i++) cyc(1, 2'b11, 2'b11, 0);
        cyc(0, 2'b01, 2'b00, 0);
        cyc(0, 2'b00, 2'b00, 0);

        // Clean limit on ch0: high from the first qualifying edge
        for (int i = 0; i <= 20; i++) cyc(0, 2'b01, (i >= BL) ? 2'b01 : 2'b00, 0);
        cyc(0, 2'b00, 2'b00, 0);

        // Limit during blanking, then a glitch before a real 4-high run
        begin
            logic [7:0] pat;
            pat = 8'b1111_0111;
            for (int i = 0; i <= 20; i++) begin
                logic l;
                l = (i >= 2 && i <= BL) ? 1'b1 :
                    (i > BL && i <= BL + 8) ? pat[i - BL - 1] : 1'b0;
                cyc(0, 2'b01, {1'b0, l}, 0);
            end
        end
        cyc(0, 2'b00, 2'b00, 0);

        // Timeout on ch1, then clear it
        for (int i = 0; i <= TO + 5; i++) cyc(0, 2'b10, 2'b00, 0);
        cyc(0, 2'b10, 2'b00, 1);
        cyc(0, 2'b00, 2'b00, 0);

        // Abort in QUAL with three highs counted
        for (int i = 0; i <= BL + 3; i++) cyc(0, 2'b01, (i > BL) ? 2'b01 : 2'b00, 0);
        cyc(0, 2'b00, 2'b01, 0);
        cyc(0, 2'b00, 2'b00, 0);

        // ch0 accepts on the timeout edge; ch1 times out while TMO clear is asserted
        for (int i = 0; i <= TO + 3; i++)
            cyc(0, 2'b11, (i > TO - HD && i <= TO) ? 2'b01 : 2'b00, (i == TO));
        cyc(0, 2'b00, 2'b00, 0);

        // ch0 stops while ch1 sweeps; ch0 restarts with a fresh blank window
        for (int i = 0; i <= 30; i++) begin
            logic e0;
            e0 = (i != 20);
            cyc(0, {1'b1, e0}, 2'b01, 0);
        end
        cyc(0, 2'b00, 2'b00, 1);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] en, lim;
            bit r, clr;
            for (int c = 0; c < N; c++) begin
                en[c]  = ($urandom_range(0, 40) != 0);
                lim[c] = ($urandom_range(0, 3) != 0);
            end
            if (bus.en != en && $urandom_range(0, 1) == 0) en = bus.en;
            clr = ($urandom_range(0, 31) == 0);
            r   = ($urandom_range(0, 499) == 0);
            cyc(r, en, lim, clr);
        end

        @(posedge clk);
        #3;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
